qam_tx_serializer: RTL and testbench
====================================

Name: qam_tx_serializer

Overview:
Parametrised output stage of the QAM transmit path, placed between the qam_mixer and the serial line.
- Generates the mixer sample-enable strobe as a single-clock enable, not a derived clock.
- Buffers mixer samples in a small FIFO with a valid/ready handshake.
- Serialises each SAMPLE_W-bit sample one bit per clk, with a last-bit strobe, underrun reporting and a synchronous flush.

Parameters:
SAMPLE_W, 8, bits per mixer sample; range 2..32.
FIFO_DEPTH, 4, sample buffer depth; power of two, ≥2.
SYM_DIV, 8, clk cycles between sample_tick pulses; ≥2.
MSB_FIRST, 0, 0 = LSB shifted out first, 1 = MSB first.
IDLE_BIT, 0, level driven on data_bit_out when no bit is valid.

Ports:
clk  in  1  system clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
en  in  1  run enable for the tick generator.
flush  in  1  synchronous clear of FIFO and serializer.
sample_tick  out  1  one-cycle strobe every SYM_DIV cycles; drives the mixer enable.
in_data  in  SAMPLE_W  sample from the mixer.
in_valid  in  1  in_data valid.
in_ready  out  1  FIFO can accept; equals !full && !flush.
data_bit_out  out  1  serial bit, registered.
bit_valid  out  1  data_bit_out carries a sample bit.
data_out_complete_bit  out  1  high with the last bit of each sample.
underrun  out  1  one-cycle pulse when the stream gaps while en=1.
fill_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
Reset (async assert, release on clk edge):
- Tick counter = 0, FIFO empty, serializer IDLE.
- sample_tick=0, data_bit_out=IDLE_BIT, bit_valid=0, data_out_complete_bit=0, underrun=0, fill_level=0.

Tick generator:
- Counter runs 0..SYM_DIV-1 while en=1.
- sample_tick is registered and high in the cycle after the counter reaches SYM_DIV-1. The first tick comes SYM_DIV cycles after en rises.
- en=0 forces counter=0 and sample_tick=0.
- flush does not affect the tick generator.

FIFO:
- Push when in_valid && in_ready.
- Pop when the serializer loads a word.
- Simultaneous push and pop when full is legal; fill_level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- A push while full cannot occur, because in_ready=0.

Serializer FSM, states IDLE and SHIFT:
- IDLE -> SHIFT when the FIFO is non-empty. The load pops the head; bit 0 of the word (or bit SAMPLE_W-1 if MSB_FIRST) appears on data_bit_out with bit_valid=1 at the same edge.
- Latency: a word pushed into an empty FIFO at edge E0 puts its first bit out at E1 and its last bit at E(SAMPLE_W).
- SHIFT: one bit per clk. A bit counter runs 0..SAMPLE_W-1. data_out_complete_bit=1 in the same cycle as the last bit.
- Last bit with FIFO non-empty: load the next word at the following edge. There is no gap, so continuous throughput is one sample per SAMPLE_W cycles.
- Last bit with FIFO empty: go to IDLE. data_bit_out=IDLE_BIT, bit_valid=0. If en=1, pulse underrun for one cycle coincident with the first idle cycle.

Flush:
- Asserting flush empties the FIFO at the next edge, aborts SHIFT to IDLE and drives the idle outputs.
- data_out_complete_bit is not asserted for the aborted word, and underrun is not pulsed.
- in_ready=0 while flush=1; a coincident in_valid is dropped.

Rate rule: the system requires SYM_DIV ≥ SAMPLE_W. A smaller SYM_DIV overproduces, and upstream back-pressure (in_ready) throttles the mixer.

Reset mid-operation: everything returns to reset values immediately; no partial word is emitted afterwards.

Decomposition:
Shared package qam_pkg:
- default SAMPLE_W and SYM_DIV constants;
- serializer state enum {IDLE, SHIFT};
- helper function for the fill_level width.

One sub-module, qam_sync_fifo: parametrised width/depth synchronous FIFO with push/pop, full/empty, level and sync clear. It is reused later by the receive path. The tick generator and FSM stay in the top.

Test Plan:
1. SAMPLE_W=8, LSB first, push 8'hA5 into empty FIFO at E0 -> bits 1,0,1,0,0,1,0,1 at E1..E8, complete at E8, then underrun pulse and bit_valid=0 at E9.
2. Push 8'h3C, 8'hF0 back-to-back -> 16 contiguous valid bits, complete at E8 and E16, no idle cycle, no underrun.
3. FIFO_DEPTH=4, hold in_valid=1 with the serializer busy -> in_ready drops when fill_level=4 and rises the cycle after a pop; no word lost or duplicated against the scoreboard.
4. en=1, SYM_DIV=8 -> sample_tick every 8th cycle, first 8 cycles after en rises; en=0 mid-count -> no tick, restart from 0.
5. flush at bit 3 of 8'hFF with 2 words queued -> next cycle bit_valid=0, fill_level=0, no complete or underrun; a subsequent push restarts at bit 0.
6. Async rst asserted mid-shift between edges -> outputs at reset values immediately; MSB_FIRST=1 rerun of scenario 1 gives 1,0,1,0,0,1,0,1 reversed order (A5 MSB first: 1,0,1,0,0,1,0,1 identical, so use 8'h96 -> 1,0,0,1,0,1,1,0).

Source files
------------

// File: rtl/qam_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qam_pkg
// Brief    : Shared types, defaults and helpers for the QAM TX/RX serial stages
// Revision : 1.0  initial release
// ============================================================================
package qam_pkg;

  localparam int c_default_sample_w = 8;
  localparam int c_default_sym_div  = 8;

  // Serializer states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Occupancy counter width: must represent 0..depth inclusive
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/qam_tx_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : qam_tx_serializer_if
// Brief    : Valid/ready sample stream from the mixer into the serializer
// Revision : 1.0  initial release
// ============================================================================
interface qam_tx_serializer_if
  import qam_pkg::*;
#(
  parameter int SAMPLE_W = c_default_sample_w
);
  logic [SAMPLE_W-1:0] in_data;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_data, output in_valid, input  in_ready);
  modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface
`default_nettype wire

// File: rtl/qam_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : qam_sync_fifo
// Brief    : Synchronous FIFO with push/pop, full/empty, level and sync clear
// Revision : 1.0  initial release
// ============================================================================
module qam_sync_fifo
  import qam_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = lvl_w(DEPTH)
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  input  wire logic             push,
  input  wire logic [WIDTH-1:0] push_data,
  input  wire logic             pop,
  output logic      [WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty,
  output logic      [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle
  assign w_push   = push && (!full || pop);
  assign w_pop    = pop && !empty;
  assign full     = (r_level == LW'(DEPTH));
  assign empty    = (r_level == '0);
  assign level    = r_level;
  assign pop_data = r_mem[r_rd_ptr];

  // Pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end

  // Storage array, no reset needed since reads are gated by the level
  always_ff @(posedge clk) begin
    if (w_push && !clr) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/qam_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : qam_tx_serializer
// Brief    : QAM TX output stage: sample-tick strobe, sample FIFO, bit serializer
// Revision : 1.0  initial release
// ============================================================================
module qam_tx_serializer
  import qam_pkg::*;
#(
  parameter  int   SAMPLE_W   = c_default_sample_w,
  parameter  int   FIFO_DEPTH = 4,
  parameter  int   SYM_DIV    = c_default_sym_div,
  parameter  int   MSB_FIRST  = 0,
  parameter  logic IDLE_BIT   = 1'b0,
  localparam int   LW         = lvl_w(FIFO_DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          en,
  input  wire logic          flush,
  output logic               sample_tick,
  qam_tx_serializer_if.slave s_in,
  output logic               data_bit_out,
  output logic               bit_valid,
  output logic               data_out_complete_bit,
  output logic               underrun,
  output logic  [LW-1:0]     fill_level
);

  localparam int TW = $clog2(SYM_DIV);
  localparam int BW = $clog2(SAMPLE_W);

  logic [TW-1:0]       r_tick_cnt;
  logic [SAMPLE_W-1:0] w_fifo_dout;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_load;

  ser_state_e          r_state, w_state_nxt;
  logic [SAMPLE_W-1:0] r_shift, w_shift_nxt;
  logic [BW-1:0]       r_bit_cnt, w_bit_cnt_nxt;
  logic                w_dout_nxt, w_bv_nxt, w_cmp_nxt, w_unr_nxt;
  logic                w_last;
  logic                w_first_bit, w_next_bit;
  logic [SAMPLE_W-1:0] w_load_rest, w_shift_adv;

  // Tick generator: free-running divider, held at zero while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick_cnt  <= '0;
      sample_tick <= 1'b0;
    end else if (!en) begin
      r_tick_cnt  <= '0;
      sample_tick <= 1'b0;
    end else if (r_tick_cnt == TW'(SYM_DIV - 1)) begin
      r_tick_cnt  <= '0;
      sample_tick <= 1'b1;
    end else begin
      r_tick_cnt  <= r_tick_cnt + 1'b1;
      sample_tick <= 1'b0;
    end
  end

  assign s_in.in_ready = !w_fifo_full && !flush;

  qam_sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (flush),
    .push      (s_in.in_valid && s_in.in_ready),
    .push_data (s_in.in_data),
    .pop       (w_load),
    .pop_data  (w_fifo_dout),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty),
    .level     (fill_level)
  );

  // Bit order: the shift register always presents the next bit at one fixed end
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign w_first_bit = w_fifo_dout[SAMPLE_W-1];
      assign w_load_rest = w_fifo_dout << 1;
      assign w_next_bit  = r_shift[SAMPLE_W-1];
      assign w_shift_adv = r_shift << 1;
    end else begin : g_lsb_first
      assign w_first_bit = w_fifo_dout[0];
      assign w_load_rest = w_fifo_dout >> 1;
      assign w_next_bit  = r_shift[0];
      assign w_shift_adv = r_shift >> 1;
    end
  endgenerate

  assign w_last = (r_state == SHIFT) && (r_bit_cnt == BW'(SAMPLE_W - 1));

  // Serializer next state and next registered outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_dout_nxt    = IDLE_BIT;
    w_bv_nxt      = 1'b0;
    w_cmp_nxt     = 1'b0;
    w_unr_nxt     = 1'b0;
    w_load        = 1'b0;
    if (flush) begin
      w_state_nxt = IDLE;
    end else if (((r_state == IDLE) || w_last) && !w_fifo_empty) begin
      // Load straight after the last bit so back-to-back words have no gap
      w_load        = 1'b1;
      w_state_nxt   = SHIFT;
      w_shift_nxt   = w_load_rest;
      w_bit_cnt_nxt = '0;
      w_dout_nxt    = w_first_bit;
      w_bv_nxt      = 1'b1;
    end else if (w_last) begin
      w_state_nxt = IDLE;
      w_unr_nxt   = en;
    end else if (r_state == SHIFT) begin
      w_shift_nxt   = w_shift_adv;
      w_bit_cnt_nxt = r_bit_cnt + 1'b1;
      w_dout_nxt    = w_next_bit;
      w_bv_nxt      = 1'b1;
      w_cmp_nxt     = (r_bit_cnt == BW'(SAMPLE_W - 2));
    end
  end

  // Serializer state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state               <= IDLE;
      r_shift               <= '0;
      r_bit_cnt             <= '0;
      data_bit_out          <= IDLE_BIT;
      bit_valid             <= 1'b0;
      data_out_complete_bit <= 1'b0;
      underrun              <= 1'b0;
    end else begin
      r_state               <= w_state_nxt;
      r_shift               <= w_shift_nxt;
      r_bit_cnt             <= w_bit_cnt_nxt;
      data_bit_out          <= w_dout_nxt;
      bit_valid             <= w_bv_nxt;
      data_out_complete_bit <= w_cmp_nxt;
      underrun              <= w_unr_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_qam_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_qam_tx_serializer
// Brief    : Self-checking bench for qam_tx_serializer (LSB and MSB instances)
// Revision : 1.0  initial release
// ============================================================================
module tb_qam_tx_serializer;
  import qam_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst, en, flush, sel_m;
  always #5 clk = ~clk;

  qam_tx_serializer_if #(.SAMPLE_W(W)) s_l ();
  qam_tx_serializer_if #(.SAMPLE_W(W)) s_m ();

  logic       tick_l, dbit_l, bv_l, cmp_l, unr_l;
  logic       tick_m, dbit_m, bv_m, cmp_m, unr_m;
  logic [2:0] fill_l, fill_m;

  qam_tx_serializer #(.SAMPLE_W(W), .FIFO_DEPTH(D), .SYM_DIV(8), .MSB_FIRST(0), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .sample_tick(tick_l), .s_in(s_l),
    .data_bit_out(dbit_l), .bit_valid(bv_l), .data_out_complete_bit(cmp_l),
    .underrun(unr_l), .fill_level(fill_l));

  qam_tx_serializer #(.SAMPLE_W(W), .FIFO_DEPTH(D), .SYM_DIV(8), .MSB_FIRST(1), .IDLE_BIT(1'b0)) dut_m (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .sample_tick(tick_m), .s_in(s_m),
    .data_bit_out(dbit_m), .bit_valid(bv_m), .data_out_complete_bit(cmp_m),
    .underrun(unr_m), .fill_level(fill_m));

  // View of whichever instance is under test
  logic dbit, bv, cmp, unr, rdy, tick;
  logic [2:0] fill;
  always_comb begin
    dbit = sel_m ? dbit_m : dbit_l;
    bv   = sel_m ? bv_m   : bv_l;
    cmp  = sel_m ? cmp_m  : cmp_l;
    unr  = sel_m ? unr_m  : unr_l;
    rdy  = sel_m ? s_m.in_ready : s_l.in_ready;
    tick = sel_m ? tick_m : tick_l;
    fill = sel_m ? fill_m : fill_l;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tk();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    s_l.in_valid = v && !sel_m;
    s_m.in_valid = v && sel_m;
    s_l.in_data  = d;
    s_m.in_data  = d;
  endtask

  // seq[7] is the first bit expected on the line
  task automatic send_check(input string name, input logic [7:0] word, input logic [7:0] seq);
    drive(1'b1, word);
    tk();
    drive(1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tk();
      chk({name, "/bv"},  bv,   1);
      chk({name, "/bit"}, dbit, seq[7-i]);
      chk({name, "/cmp"}, cmp,  (i == 7));
      chk({name, "/unr"}, unr,  0);
    end
    tk();
    chk({name, "/idle_bv"},  bv,   0);
    chk({name, "/idle_bit"}, dbit, 0);
    chk({name, "/underrun"}, unr,  1);
    tk();
    chk({name, "/unr_once"}, unr,  0);
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq;
  } vec_t;
  vec_t vecs[4];

  logic        bitq[$];
  int          pushed, started, idx, saw_full;
  logic        prev_cmp, push_s, exp_bit, v;
  logic [7:0]  push_w;
  logic [15:0] seq2;

  initial begin
    vecs[0] = '{8'hA5, 8'b10100101};
    vecs[1] = '{8'h01, 8'b10000000};
    vecs[2] = '{8'hF0, 8'b00001111};
    vecs[3] = '{8'hC5, 8'b10100011};

    sel_m = 1'b0; rst = 1'b1; en = 1'b0; flush = 1'b0;
    drive(1'b0, 8'h00);
    tk();
    chk("rst/tick", tick, 0);
    chk("rst/bv",   bv,   0);
    chk("rst/bit",  dbit, 0);
    chk("rst/cmp",  cmp,  0);
    chk("rst/unr",  unr,  0);
    chk("rst/fill", fill, 0);
    chk("rst/rdy",  rdy,  1);
    tk();
    rst = 1'b0;

    // Tick generator
    for (int k = 0; k < 3; k++) begin tk(); chk("tick/off", tick, 0); end
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin tk(); chk("tick/run", tick, (k % 8) == 0); end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin tk(); chk("tick/stop", tick, 0); end
    en = 1'b1;
    for (int k = 1; k <= 9; k++) begin tk(); chk("tick/restart", tick, k == 8); end

    // Single words into an empty FIFO
    for (int i = 0; i < 4; i++) send_check($sformatf("vec%0d", i), vecs[i].word, vecs[i].seq);

    // Back-to-back words: contiguous stream
    seq2 = {8'b00111100, 8'b00001111};
    drive(1'b1, 8'h3C); tk();
    drive(1'b1, 8'hF0); tk();
    drive(1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      if (i > 0) tk();
      chk("b2b/bv",  bv,   1);
      chk("b2b/bit", dbit, seq2[15-i]);
      chk("b2b/cmp", cmp,  (i == 7) || (i == 15));
      chk("b2b/unr", unr,  0);
    end
    tk();
    chk("b2b/end_bv",  bv,  0);
    chk("b2b/end_unr", unr, 1);
    tk();

    // Flush mid-word with two words queued
    drive(1'b1, 8'hFF); tk();
    drive(1'b1, 8'h11); tk();
    drive(1'b1, 8'h22); tk();
    drive(1'b0, 8'h00); tk();
    tk();
    chk("flush/pre_bv",   bv,   1);
    chk("flush/pre_fill", fill, 2);
    flush = 1'b1;
    drive(1'b1, 8'h33);
    #1;
    chk("flush/rdy", rdy, 0);
    tk();
    flush = 1'b0;
    drive(1'b0, 8'h00);
    chk("flush/bv",   bv,   0);
    chk("flush/bit",  dbit, 0);
    chk("flush/fill", fill, 0);
    chk("flush/cmp",  cmp,  0);
    chk("flush/unr",  unr,  0);
    tk();
    chk("flush/after_bv",   bv,   0);
    chk("flush/after_unr",  unr,  0);
    chk("flush/after_fill", fill, 0);
    send_check("restart", 8'h01, 8'b10000000);

    // Asynchronous reset between edges while shifting
    drive(1'b1, 8'hA5); tk();
    drive(1'b0, 8'h00); tk(); tk(); tk();
    chk("arst/pre_bv", bv, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst/bv",   bv,   0);
    chk("arst/bit",  dbit, 0);
    chk("arst/fill", fill, 0);
    chk("arst/cmp",  cmp,  0);
    chk("arst/tick", tick, 0);
    tk();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tk();
      chk("arst/quiet_bv",  bv,  0);
      chk("arst/quiet_unr", unr, 0);
    end

    // MSB-first instance
    sel_m = 1'b1;
    send_check("msb", 8'h96, 8'b10010110);
    sel_m = 1'b0;
    drive(1'b0, 8'h00);

    // Randomised run against a bit-stream reference model
    pushed = 0; started = 0; idx = 0; saw_full = 0; prev_cmp = 1'b0;
    for (int c = 0; c < 860; c++) begin
      if (c >= 800) v = 1'b0;
      else v = ($urandom_range(0, 99) < (((c / 100) % 2) != 0 ? 92 : 35));
      drive(v, 8'($urandom));
      @(negedge clk);
      push_s = s_l.in_valid && s_l.in_ready;
      push_w = s_l.in_data;
      tk();
      if (push_s) begin
        for (int b = 0; b < 8; b++) bitq.push_back(push_w[b]);
        pushed++;
      end
      if (bv) begin
        if (bitq.size() == 0) begin
          chk("rand/unexpected_bit", 1, 0);
        end else begin
          exp_bit = bitq.pop_front();
          chk("rand/bit", dbit, exp_bit);
        end
        if (idx == 0) started++;
        chk("rand/cmp", cmp, idx == 7);
        idx = (idx + 1) % 8;
      end else begin
        chk("rand/idle_bit", dbit, 0);
        chk("rand/idle_cmp", cmp,  0);
      end
      chk("rand/unr",  unr,  prev_cmp && !bv);
      chk("rand/fill", fill, pushed - started);
      chk("rand/rdy",  rdy,  (pushed - started) != D);
      if (fill == 3'(D)) saw_full++;
      prev_cmp = cmp;
    end
    chk("rand/drained",  bitq.size(), 0);
    chk("rand/saw_full", saw_full > 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
